dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller. It is the requester side of the data-memory interface.
- It sits between the pipeline MEM stage and a multi-cycle line-granular data memory.
- It accepts one word load/store at a time from the pipeline, then issues line writebacks and refills to memory.
- It stalls the pipeline via is_ready until the access completes.

---
 rtl/dcache_pkg.sv | 42 ++++
 rtl/dcache_ctrl_if.sv | 33 +++
 rtl/dcache_line_store.sv | 58 +++++
 rtl/dcache_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache controller.
package dcache_pkg;

    localparam int unsigned DEF_NUM_SETS   = 16;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DEF_LINE_BITS  = WORD_W * DEF_LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        TAG_CHECK,
        WRITEBACK,
        ALLOCATE
    } state_e;

    // Request captured from the pipeline when it is accepted
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [WORD_W-1:0] din;
    } cpu_req_t;

    function automatic logic [31:0] field_mask(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] a, input int unsigned off_w);
        return (a >> 2) & field_mask(off_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned off_w,
                                               input int unsigned idx_w);
        return (a >> (off_w + 2)) & field_mask(idx_w);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned off_w,
                                             input int unsigned idx_w);
        return a >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline-side and memory-side bus bundles of the data cache controller.
interface dcache_cpu_if;
    logic        is_input_valid;
    logic [31:0] addr;
    logic        mem_rw;
    logic [31:0] din;
    logic        is_ready;
    logic        is_output_valid;
    logic [31:0] dout;
    logic        is_hit;

    modport master (output is_input_valid, addr, mem_rw, din,
                    input  is_ready, is_output_valid, dout, is_hit);
    modport slave  (input  is_input_valid, addr, mem_rw, din,
                    output is_ready, is_output_valid, dout, is_hit);
endinterface

interface dcache_mem_if #(
    parameter int unsigned LINE_BITS = 128
);
    logic                 mem_req_valid;
    logic                 mem_req_write;
    logic [31:0]          mem_req_addr;
    logic [LINE_BITS-1:0] mem_req_data;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic [LINE_BITS-1:0] mem_resp_data;

    modport master (output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
                    input  mem_req_ready, mem_resp_valid, mem_resp_data);
    modport slave  (input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
                    output mem_req_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: asynchronous read, synchronous word and line writes.
module dcache_line_store #(
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_SETS)-1:0]    idx_i,
    output logic [TAG_W-1:0]               rd_tag_o,
    output logic                           rd_valid_o,
    output logic                           rd_dirty_o,
    output logic [LINE_WORDS-1:0][31:0]    rd_line_o,
    input  logic                           word_we_i,
    input  logic [$clog2(LINE_WORDS)-1:0]  word_sel_i,
    input  logic [31:0]                    word_data_i,
    input  logic                           line_we_i,
    input  logic [TAG_W-1:0]               line_tag_i,
    input  logic [LINE_WORDS-1:0][31:0]    line_data_i,
    input  logic                           dirty_clr_i
);

    logic [LINE_WORDS-1:0][31:0] data_q  [NUM_SETS];
    logic [TAG_W-1:0]            tag_q   [NUM_SETS];
    logic [NUM_SETS-1:0]         valid_q;
    logic [NUM_SETS-1:0]         dirty_q;

    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    // Data and tag payload; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_data_i;
            tag_q[idx_i]  <= line_tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_sel_i] <= word_data_i;
        end
    end

    // Line state bits; a refill always lands clean, a store hit marks the line dirty
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (dirty_clr_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int unsigned LINE_BITS = WORD_W * LINE_WORDS;
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W     = $clog2(NUM_SETS);
    localparam int unsigned TAG_W     = 30 - OFF_W - IDX_W;

    state_e               state_q;
    cpu_req_t             req_q;
    logic                 first_check_q;
    logic                 is_ready_q;
    logic                 out_valid_q;
    logic                 is_hit_q;
    logic [31:0]          dout_q;
    logic                 mem_req_valid_q;
    logic                 mem_req_write_q;
    logic [31:0]          mem_req_addr_q;
    logic [LINE_BITS-1:0] mem_req_data_q;

    logic [TAG_W-1:0]            req_tag;
    logic [IDX_W-1:0]            req_idx;
    logic [OFF_W-1:0]            req_word;
    logic [TAG_W-1:0]            rd_tag;
    logic                        rd_valid;
    logic                        rd_dirty;
    logic [LINE_WORDS-1:0][31:0] rd_line;
    logic                        hit;
    logic                        resp_wait;
    logic                        word_we;
    logic                        line_we;
    logic                        dirty_clr;

    assign req_tag  = TAG_W'(addr_tag(req_q.addr, OFF_W, IDX_W));
    assign req_idx  = IDX_W'(addr_index(req_q.addr, OFF_W, IDX_W));
    assign req_word = OFF_W'(addr_word(req_q.addr, OFF_W));

    // Request already handed to memory; only now does a response count
    assign resp_wait = !mem_req_valid_q && mem.mem_resp_valid;
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign word_we   = (state_q == TAG_CHECK) && hit && req_q.rw;
    assign line_we   = (state_q == ALLOCATE) && resp_wait;
    assign dirty_clr = (state_q == WRITEBACK) && resp_wait;

    dcache_line_store #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .idx_i       (req_idx),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_line_o   (rd_line),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_data_i (req_q.din),
        .line_we_i   (line_we),
        .line_tag_i  (req_tag),
        .line_data_i (mem.mem_resp_data),
        .dirty_clr_i (dirty_clr)
    );

    assign cpu.is_ready        = is_ready_q;
    assign cpu.is_output_valid = out_valid_q;
    assign cpu.dout            = dout_q;
    assign cpu.is_hit          = is_hit_q;
    assign mem.mem_req_valid   = mem_req_valid_q;
    assign mem.mem_req_write   = mem_req_write_q;
    assign mem.mem_req_addr    = mem_req_addr_q;
    assign mem.mem_req_data    = mem_req_data_q;

    // Controller FSM with registered pipeline and memory-request outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            req_q           <= '0;
            first_check_q   <= 1'b0;
            is_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            is_hit_q        <= 1'b0;
            dout_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.is_input_valid) begin
                        req_q         <= '{addr: cpu.addr, rw: cpu.mem_rw, din: cpu.din};
                        first_check_q <= 1'b1;
                        is_ready_q    <= 1'b0;
                        state_q       <= TAG_CHECK;
                    end
                end
                TAG_CHECK: begin
                    if (hit) begin
                        if (!req_q.rw) begin
                            dout_q <= rd_line[req_word];
                        end
                        out_valid_q <= 1'b1;
                        is_hit_q    <= first_check_q;
                        is_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        first_check_q   <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            mem_req_write_q <= 1'b1;
                            mem_req_addr_q  <= {rd_tag, req_idx, {(OFF_W + 2){1'b0}}};
                            mem_req_data_q  <= rd_line;
                            state_q         <= WRITEBACK;
                        end else begin
                            mem_req_write_q <= 1'b0;
                            mem_req_addr_q  <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                            state_q         <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_req_valid_q) begin
                        if (mem.mem_req_ready) begin
                            mem_req_valid_q <= 1'b0;
                        end
                    end else if (mem.mem_resp_valid) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                        state_q         <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_req_valid_q) begin
                        if (mem.mem_req_ready) begin
                            mem_req_valid_q <= 1'b0;
                        end
                    end else if (mem.mem_resp_valid) begin
                        state_q <= TAG_CHECK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Completion counters, classified by whether the first tag check hit
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (out_valid_q) begin
            if (is_hit_q) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-granular memory model.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int unsigned LB = DEF_LINE_BITS;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dcache_cpu_if cpu ();
    dcache_mem_if #(.LINE_BITS(LB)) mi ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu),
        .mem   (mi)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model state
    int          ready_delay;
    int          resp_delay;
    int          req_cycles;
    int          wait_cnt;
    int          resp_cnt;
    bit          resp_pend;
    logic        pend_write;
    logic [31:0] pend_addr;
    logic [LB-1:0] pend_data;
    logic [LB-1:0] mem_store [logic [31:0]];
    logic [31:0]   log_addr [$];
    logic          log_write [$];
    logic [LB-1:0] log_data [$];

    initial begin : mem_model
        ready_delay = 3;
        resp_delay  = 0;
        req_cycles  = 0;
        wait_cnt    = 0;
        resp_cnt    = 0;
        resp_pend   = 1'b0;
        mi.mem_req_ready  = 1'b0;
        mi.mem_resp_valid = 1'b0;
        mi.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mi.mem_req_ready  = 1'b0;
            mi.mem_resp_valid = 1'b0;
            if (mi.mem_req_valid) req_cycles++;
            if (mi.mem_req_valid && !reset) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    mi.mem_req_ready = 1'b1;
                    wait_cnt   = 0;
                    pend_write = mi.mem_req_write;
                    pend_addr  = mi.mem_req_addr;
                    pend_data  = mi.mem_req_data;
                    resp_pend  = 1'b1;
                    resp_cnt   = 0;
                    log_addr.push_back(mi.mem_req_addr);
                    log_write.push_back(mi.mem_req_write);
                    log_data.push_back(mi.mem_req_data);
                end
            end else if (resp_pend) begin
                if (resp_cnt < resp_delay) begin
                    resp_cnt++;
                end else begin
                    resp_pend = 1'b0;
                    mi.mem_resp_valid = 1'b1;
                    if (pend_write) mem_store[pend_addr] = pend_data;
                    else mi.mem_resp_data = mem_store.exists(pend_addr) ? mem_store[pend_addr] : '0;
                end
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_write.delete();
        log_data.delete();
    endtask

    // One request from an idle controller; lat counts clock edges after acceptance
    task automatic do_access(input logic [31:0] a, input logic rw, input logic [31:0] d,
                             output logic [31:0] rd, output logic hit, output int lat,
                             output logic ok);
        @(negedge clk);
        cpu.is_input_valid = 1'b1;
        cpu.addr   = a;
        cpu.mem_rw = rw;
        cpu.din    = d;
        @(negedge clk);
        cpu.is_input_valid = 1'b0;
        lat = 0;
        ok  = 1'b0;
        rd  = 'x;
        hit = 1'bx;
        for (int i = 0; i < 300; i++) begin
            if (cpu.is_output_valid) begin
                ok  = 1'b1;
                rd  = cpu.dout;
                hit = cpu.is_hit;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (cpu.is_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", cpu.is_ready); end
        total++; if (cpu.is_output_valid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b expected 0", cpu.is_output_valid); end
        total++; if (cpu.is_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b expected 0", cpu.is_hit); end
        total++; if (cpu.dout !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h expected 0", cpu.dout); end
        total++; if (mi.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mreq: got %b expected 0", mi.mem_req_valid); end
    endtask

    task automatic test_cold_load();
        logic [31:0] rd; logic hit; int lat; logic ok;
        ready_delay = 3; resp_delay = 0;
        clear_log();
        do_access(32'h100, 1'b0, 32'h0, rd, hit, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL cold_done: got %b expected 1", ok); end
        total++; if (rd !== 32'h11) begin bad++; $display("FAIL cold_dout: got %h expected 00000011", rd); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL cold_hit: got %b expected 0", hit); end
        total++; if (lat != 7) begin bad++; $display("FAIL cold_latency: got %0d expected 7", lat); end
        total++; if (log_addr.size() != 1) begin bad++; $display("FAIL cold_nreq: got %0d expected 1", log_addr.size()); end
        else begin
            total++; if (log_addr[0] !== 32'h100) begin bad++; $display("FAIL cold_req_addr: got %h expected 00000100", log_addr[0]); end
            total++; if (log_write[0] !== 1'b0) begin bad++; $display("FAIL cold_req_write: got %b expected 0", log_write[0]); end
        end
    endtask

    task automatic test_hit();
        logic [31:0] rd; logic hit; int lat; logic ok; int rc0;
        rc0 = req_cycles;
        do_access(32'h10C, 1'b0, 32'h0, rd, hit, lat, ok);
        total++; if (rd !== 32'h44) begin bad++; $display("FAIL hit_dout: got %h expected 00000044", rd); end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL hit_flag: got %b expected 1", hit); end
        total++; if (lat != 1) begin bad++; $display("FAIL hit_latency: got %0d expected 1", lat); end
        total++; if (req_cycles != rc0) begin bad++; $display("FAIL hit_no_mreq: got %0d expected %0d", req_cycles, rc0); end
    endtask

    task automatic test_dirty_miss();
        logic [31:0] rd; logic hit; int lat; logic ok;
        logic [LB-1:0] exp_wb;
        exp_wb = {32'h44, 32'h33, 32'hDEADBEEF, 32'h11};
        do_access(32'h104, 1'b1, 32'hDEADBEEF, rd, hit, lat, ok);
        total++; if (hit !== 1'b1 || lat != 1) begin bad++; $display("FAIL store_hit: got hit=%b lat=%0d expected hit=1 lat=1", hit, lat); end
        clear_log();
        do_access(32'h504, 1'b0, 32'h0, rd, hit, lat, ok);
        total++; if (rd !== 32'h66) begin bad++; $display("FAIL dirty_dout: got %h expected 00000066", rd); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL dirty_hit: got %b expected 0", hit); end
        total++; if (lat != 12) begin bad++; $display("FAIL dirty_latency: got %0d expected 12", lat); end
        total++; if (log_addr.size() != 2) begin bad++; $display("FAIL dirty_nreq: got %0d expected 2", log_addr.size()); end
        else begin
            total++; if (log_write[0] !== 1'b1 || log_addr[0] !== 32'h100) begin bad++; $display("FAIL wb_req: got write=%b addr=%h expected write=1 addr=00000100", log_write[0], log_addr[0]); end
            total++; if (log_data[0] !== exp_wb) begin bad++; $display("FAIL wb_data: got %h expected %h", log_data[0], exp_wb); end
            total++; if (log_write[1] !== 1'b0 || log_addr[1] !== 32'h500) begin bad++; $display("FAIL refill_req: got write=%b addr=%h expected write=0 addr=00000500", log_write[1], log_addr[1]); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic hit; int lat; logic ok; int wb_cycles; bit done;
        logic [LB-1:0] exp_wb;
        exp_wb = {32'h88, 32'h77, 32'hCAFEF00D, 32'h55};
        do_access(32'h504, 1'b1, 32'hCAFEF00D, rd, hit, lat, ok);
        ready_delay = 5;
        @(negedge clk);
        cpu.is_input_valid = 1'b1;
        cpu.addr = 32'h108; cpu.mem_rw = 1'b0; cpu.din = 32'h0;
        @(negedge clk);
        cpu.is_input_valid = 1'b0;
        wb_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cpu.is_output_valid) begin
                done = 1'b1;
                total++; if (cpu.dout !== 32'h33) begin bad++; $display("FAIL stall_dout: got %h expected 00000033", cpu.dout); end
                total++; if (cpu.is_hit !== 1'b0) begin bad++; $display("FAIL stall_hit: got %b expected 0", cpu.is_hit); end
                break;
            end
            total++; if (cpu.is_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: cycle %0d got %b expected 0", i, cpu.is_ready); end
            if (mi.mem_req_valid && mi.mem_req_write) begin
                wb_cycles++;
                total++; if (mi.mem_req_addr !== 32'h500) begin bad++; $display("FAIL stall_addr: got %h expected 00000500", mi.mem_req_addr); end
                total++; if (mi.mem_req_data !== exp_wb) begin bad++; $display("FAIL stall_data: got %h expected %h", mi.mem_req_data, exp_wb); end
            end
            @(negedge clk);
        end
        total++; if (!done) begin bad++; $display("FAIL stall_timeout: got no completion expected completion"); end
        total++; if (wb_cycles != 6) begin bad++; $display("FAIL stall_wb_cycles: got %0d expected 6", wb_cycles); end
        ready_delay = 3;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu.is_input_valid = 1'b1; cpu.addr = 32'h100; cpu.mem_rw = 1'b0; cpu.din = 32'h0;
        @(negedge clk);
        cpu.addr = 32'h20C; cpu.din = 32'hBAD0BAD0;
        @(negedge clk);
        total++; if (cpu.is_output_valid !== 1'b1 || cpu.dout !== 32'h11 || cpu.is_hit !== 1'b1) begin
            bad++; $display("FAIL b2b_first: got v=%b dout=%h hit=%b expected v=1 dout=00000011 hit=1", cpu.is_output_valid, cpu.dout, cpu.is_hit); end
        total++; if (cpu.is_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b expected 1", cpu.is_ready); end
        cpu.addr = 32'h10C; cpu.din = 32'h0;
        @(negedge clk);
        total++; if (cpu.is_output_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b expected 0", cpu.is_output_valid); end
        cpu.addr = 32'h208;
        @(negedge clk);
        cpu.is_input_valid = 1'b0;
        total++; if (cpu.is_output_valid !== 1'b1 || cpu.dout !== 32'h44 || cpu.is_hit !== 1'b1) begin
            bad++; $display("FAIL b2b_second: got v=%b dout=%h hit=%b expected v=1 dout=00000044 hit=1", cpu.is_output_valid, cpu.dout, cpu.is_hit); end
        @(negedge clk);
        total++; if (cpu.is_output_valid !== 1'b0 || cpu.is_ready !== 1'b1 || mi.mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_ignored: got v=%b rdy=%b mreq=%b expected v=0 rdy=1 mreq=0", cpu.is_output_valid, cpu.is_ready, mi.mem_req_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic hit; int lat; logic ok; bit seen; int pulses;
        resp_delay = 8;
        @(negedge clk);
        cpu.is_input_valid = 1'b1; cpu.addr = 32'h210; cpu.mem_rw = 1'b0; cpu.din = 32'h0;
        @(negedge clk);
        cpu.is_input_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mi.mem_req_valid) seen = 1'b1;
            else if (seen) break;
            @(negedge clk);
        end
        total++; if (!seen || mi.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_handshake: got seen=%b mreq=%b expected seen=1 mreq=0", seen, mi.mem_req_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (cpu.is_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b expected 1", cpu.is_ready); end
        total++; if (mi.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_mreq: got %b expected 0", mi.mem_req_valid); end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cpu.is_output_valid || mi.mem_req_valid) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_late_resp: got %0d activity cycles expected 0", pulses); end
        resp_delay = 0;
        do_access(32'h210, 1'b0, 32'h0, rd, hit, lat, ok);
        total++; if (rd !== 32'hA1 || hit !== 1'b0 || lat != 7) begin
            bad++; $display("FAIL rstmid_reload: got dout=%h hit=%b lat=%0d expected dout=000000a1 hit=0 lat=7", rd, hit, lat); end
        do_access(32'h10C, 1'b0, 32'h0, rd, hit, lat, ok);
        total++; if (rd !== 32'h44 || hit !== 1'b0) begin
            bad++; $display("FAIL rstmid_invalidated: got dout=%h hit=%b expected dout=00000044 hit=0", rd, hit); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic hit; int lat; logic ok;
        apply_reset();
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            bad++; $display("FAIL stats_reset: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count); end
        do_access(32'h300, 1'b0, 32'h0, rd, hit, lat, ok);
        do_access(32'h304, 1'b0, 32'h0, rd, hit, lat, ok);
        do_access(32'h308, 1'b1, 32'h12345678, rd, hit, lat, ok);
        do_access(32'h310, 1'b0, 32'h0, rd, hit, lat, ok);
        @(negedge clk);
        @(negedge clk);
        total++; if (hit_count !== 32'd2) begin bad++; $display("FAIL stats_hits: got %0d expected 2", hit_count); end
        total++; if (miss_count !== 32'd2) begin bad++; $display("FAIL stats_misses: got %0d expected 2", miss_count); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        cpu.is_input_valid = 1'b0;
        cpu.addr   = 32'h0;
        cpu.mem_rw = 1'b0;
        cpu.din    = 32'h0;
        mem_store[32'h100] = {32'h44, 32'h33, 32'h22, 32'h11};
        mem_store[32'h500] = {32'h88, 32'h77, 32'h66, 32'h55};
        mem_store[32'h210] = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        test_reset();
        test_cold_load();
        test_hit();
        test_dirty_miss();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
